// File: rtl/traffic_lamp_driver_if.sv
// Signal bundle between the traffic sequencer and the lamp driver.
// Carries the four head codes, the fault-clear request, and the lamp enables plus fault flag.
interface traffic_lamp_driver_if;
    logic [2:0] h_car_traffic;
    logic [2:0] v_car_traffic;
    logic [2:0] h_walker_traffic;
    logic [2:0] v_walker_traffic;
    logic       fault_clear;
    logic [3:0] h_car_lamp;
    logic [3:0] v_car_lamp;
    logic [1:0] h_walker_lamp;
    logic [1:0] v_walker_lamp;
    logic       fault;

    modport master (
        output h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic, fault_clear,
        input  h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault
    );

    modport slave (
        input  h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic, fault_clear,
        output h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault
    );
endinterface

// File: rtl/traffic_lamp_driver.sv
// Turns signal-state codes into per-lamp enables, with walker twinkle blink,
// a conflict/invalid-code monitor, safe all-red override and a latched flashing-red fault mode.
module traffic_lamp_driver #(
    parameter int unsigned BLINK_HALF   = 4,
    parameter int unsigned FAULT_FILTER = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_lamp_driver_if.slave        bus
);
    localparam logic [2:0] C_RED     = 3'd0;
    localparam logic [2:0] C_GREEN   = 3'd1;
    localparam logic [2:0] C_YELLOW  = 3'd2;
    localparam logic [2:0] C_LEFT    = 3'd3;
    localparam logic [2:0] C_TWINKLE = 3'd4;

    localparam logic [3:0] CAR_SAFE  = 4'b0001;
    localparam logic [1:0] WALK_SAFE = 2'b01;

    typedef enum logic {ST_RUN, ST_FAULT} state_e;

    state_e     state, state_next;
    logic [3:0] conf_cnt, conf_next;
    logic [2:0] s_h_car, s_v_car, s_h_walker, s_v_walker;
    logic [7:0] blink_cnt;
    logic       phase;
    logic       bad;
    logic [3:0] h_car_d, v_car_d;
    logic [1:0] h_walker_d, v_walker_d;
    logic [3:0] h_car_q, v_car_q;
    logic [1:0] h_walker_q, v_walker_q;

    function automatic logic car_ok(input logic [2:0] c);
        return c <= C_LEFT;
    endfunction

    function automatic logic walk_ok(input logic [2:0] c);
        return (c == C_RED) || (c == C_GREEN) || (c == C_TWINKLE);
    endfunction

    function automatic logic [3:0] car_decode(input logic [2:0] c);
        case (c)
            C_GREEN:  return 4'b0100;
            C_YELLOW: return 4'b0010;
            C_LEFT:   return 4'b1001;
            default:  return CAR_SAFE;
        endcase
    endfunction

    function automatic logic [1:0] walk_decode(input logic [2:0] c, input logic ph);
        case (c)
            C_GREEN:   return 2'b10;
            C_TWINKLE: return {ph, 1'b0};
            default:   return WALK_SAFE;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_h_car    <= C_RED;
            s_v_car    <= C_RED;
            s_h_walker <= C_RED;
            s_v_walker <= C_RED;
        end else begin
            s_h_car    <= bus.h_car_traffic;
            s_v_car    <= bus.v_car_traffic;
            s_h_walker <= bus.h_walker_traffic;
            s_v_walker <= bus.v_walker_traffic;
        end
    end

    // Shared by walker twinkle and fault flash so the two stay in step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == 8'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 8'd1;
        end
    end

    always_comb begin
        bad = !car_ok(s_h_car) || !car_ok(s_v_car)
           || !walk_ok(s_h_walker) || !walk_ok(s_v_walker)
           || ((s_h_car != C_RED) && (s_v_car != C_RED))
           || ((s_h_car != C_RED) && (s_h_walker != C_RED))
           || ((s_v_car != C_RED) && (s_v_walker != C_RED));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            conf_cnt <= '0;
        end else begin
            state    <= state_next;
            conf_cnt <= conf_next;
        end
    end

    always_comb begin
        state_next = state;
        conf_next  = '0;
        case (state)
            ST_RUN: begin
                if (bad) begin
                    conf_next = conf_cnt + 4'd1;
                    if (conf_cnt == 4'(FAULT_FILTER - 1))
                        state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear && !bad)
                    state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        h_car_d    = CAR_SAFE;
        v_car_d    = CAR_SAFE;
        h_walker_d = WALK_SAFE;
        v_walker_d = WALK_SAFE;
        case (state)
            ST_RUN: begin
                if (!bad) begin
                    h_car_d    = car_decode(s_h_car);
                    v_car_d    = car_decode(s_v_car);
                    h_walker_d = walk_decode(s_h_walker, phase);
                    v_walker_d = walk_decode(s_v_walker, phase);
                end
            end
            ST_FAULT: begin
                h_car_d    = {3'b000, phase};
                v_car_d    = {3'b000, phase};
                h_walker_d = '0;
                v_walker_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_car_q    <= CAR_SAFE;
            v_car_q    <= CAR_SAFE;
            h_walker_q <= WALK_SAFE;
            v_walker_q <= WALK_SAFE;
        end else begin
            h_car_q    <= h_car_d;
            v_car_q    <= v_car_d;
            h_walker_q <= h_walker_d;
            v_walker_q <= v_walker_d;
        end
    end

    assign bus.h_car_lamp    = h_car_q;
    assign bus.v_car_lamp    = v_car_q;
    assign bus.h_walker_lamp = h_walker_q;
    assign bus.v_walker_lamp = v_walker_q;
    assign bus.fault         = (state == ST_FAULT);
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Self-checking bench for traffic_lamp_driver: directed scenarios plus randomized
// code patterns, checked every cycle against a cycle-indexed behavioural model.
module tb_traffic_lamp_driver;
    localparam int unsigned BH = 4;
    localparam int unsigned FF = 2;

    logic clk = 1'b0;
    logic rst_n;
    traffic_lamp_driver_if bus ();

    traffic_lamp_driver #(.BLINK_HALF(BH), .FAULT_FILTER(FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state after the most recent edge
    int         m_s [4];   // sampled codes: h_car, v_car, h_walker, v_walker
    bit         m_fault;
    int         m_run;     // consecutive bad samples seen while running
    int         m_t;       // edges since the last reset edge
    logic [3:0] e_hc, e_vc;
    logic [1:0] e_hw, e_vw;

    const logic [3:0] car_tab [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1001};

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, act, exp);
        end
    endtask

    function automatic bit is_bad(input int s [4]);
        bit bad_code;
        bad_code = (s[0] > 3) || (s[1] > 3)
                || !(s[2] inside {0, 1, 4}) || !(s[3] inside {0, 1, 4});
        return bad_code || (s[0] != 0 && s[1] != 0) || (s[0] != 0 && s[2] != 0)
                        || (s[1] != 0 && s[3] != 0);
    endfunction

    function automatic logic [1:0] walk_exp(input int c, input bit ph);
        if (c == 1) return 2'b10;
        if (c == 4) return {ph, 1'b0};
        return 2'b01;
    endfunction

    task automatic model_step(input bit rst, input int hc, input int vc,
                              input int hw, input int vw, input bit clr);
        bit ph, bad;
        if (rst) begin
            m_s = '{0, 0, 0, 0};
            m_fault = 0; m_run = 0; m_t = 0;
            e_hc = 4'b0001; e_vc = 4'b0001; e_hw = 2'b01; e_vw = 2'b01;
            return;
        end
        ph  = ((m_t / BH) % 2) == 0;
        bad = is_bad(m_s);
        if (m_fault) begin
            e_hc = {3'b000, ph}; e_vc = {3'b000, ph}; e_hw = 2'b00; e_vw = 2'b00;
        end else if (bad) begin
            e_hc = 4'b0001; e_vc = 4'b0001; e_hw = 2'b01; e_vw = 2'b01;
        end else begin
            e_hc = car_tab[m_s[0]]; e_vc = car_tab[m_s[1]];
            e_hw = walk_exp(m_s[2], ph); e_vw = walk_exp(m_s[3], ph);
        end
        if (m_fault) begin
            m_fault = !(clr && !bad);
            m_run   = 0;
        end else begin
            m_fault = bad && (m_run == int'(FF) - 1);
            m_run   = bad ? m_run + 1 : 0;
        end
        m_s = '{hc, vc, hw, vw};
        m_t++;
    endtask

    task automatic cycle(input bit rst, input int hc, input int vc,
                         input int hw, input int vw, input bit clr);
        rst_n                = !rst;
        bus.h_car_traffic    = 3'(hc);
        bus.v_car_traffic    = 3'(vc);
        bus.h_walker_traffic = 3'(hw);
        bus.v_walker_traffic = 3'(vw);
        bus.fault_clear      = clr;
        @(posedge clk);
        model_step(rst, hc, vc, hw, vw, clr);
        #1;
        check("h_car_lamp", bus.h_car_lamp, e_hc);
        check("v_car_lamp", bus.v_car_lamp, e_vc);
        check("h_walker_lamp", {2'b00, bus.h_walker_lamp}, {2'b00, e_hw});
        check("v_walker_lamp", {2'b00, bus.v_walker_lamp}, {2'b00, e_vw});
        check("fault", {3'b000, bus.fault}, {3'b000, m_fault});
    endtask

    task automatic hold(input int n, input int hc, input int vc,
                        input int hw, input int vw, input bit clr);
        for (int i = 0; i < n; i++) cycle(0, hc, vc, hw, vw, clr);
    endtask

    task automatic good_pattern(output int hc, output int vc, output int hw, output int vw);
        int walk_codes [3] = '{0, 1, 4};
        int dir;
        hc = 0; vc = 0;
        hw = walk_codes[$urandom_range(0, 2)];
        vw = walk_codes[$urandom_range(0, 2)];
        dir = $urandom_range(0, 2);
        if (dir == 1) begin hc = $urandom_range(0, 3); if (hc != 0) hw = 0; end
        if (dir == 2) begin vc = $urandom_range(0, 3); if (vc != 0) vw = 0; end
    endtask

    initial begin
        int hc, vc, hw, vw, len;
        bit clr;

        // Reset with arbitrary inputs
        for (int i = 0; i < 3; i++)
            cycle(1, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));

        // Normal decode, then LEFT
        hold(3, 1, 0, 0, 1, 0);
        hold(3, 3, 0, 0, 1, 0);
        hold(2, 2, 0, 0, 0, 0);

        // Twinkle from reset
        cycle(1, 0, 0, 0, 0, 0);
        hold(20, 0, 0, 0, 4, 0);

        // Single-cycle conflict is filtered
        hold(3, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        hold(4, 1, 0, 0, 0, 0);

        // Latched fault, clear ignored while conflicting, then recovery
        hold(12, 1, 0, 1, 0, 0);
        hold(5, 1, 0, 1, 0, 1);
        hold(3, 1, 0, 0, 0, 1);
        hold(3, 1, 0, 0, 0, 0);

        // Invalid code fault, reset mid-fault, invalid walker code
        hold(10, 7, 0, 0, 0, 0);
        cycle(1, 7, 0, 0, 0, 0);
        hold(3, 0, 0, 0, 0, 0);
        hold(8, 0, 0, 0, 2, 0);
        hold(3, 0, 0, 0, 0, 1);

        // Randomized patterns held for short runs
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 99) < 70) begin
                good_pattern(hc, vc, hw, vw);
            end else begin
                hc = $urandom_range(0, 7); vc = $urandom_range(0, 7);
                hw = $urandom_range(0, 7); vw = $urandom_range(0, 7);
            end
            len = $urandom_range(1, 6);
            clr = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 2) cycle(1, hc, vc, hw, vw, clr);
            hold(len, hc, vc, hw, vw, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
